// File: rtl/fetch_mem_arbiter_if.sv
// Request/response bundle between the fetch and load stages, the arbiter,
// and the byte-wide synchronous-read memory.
interface fetch_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                     if_req;
  logic [31:0]              if_addr;
  logic                     if_ready;
  logic                     if_valid;
  logic [DATA_WIDTH-1:0]    if_rdata;

  logic                     ls_req;
  logic [31:0]              ls_addr;
  logic                     ls_ready;
  logic                     ls_valid;
  logic [DATA_WIDTH-1:0]    ls_rdata;

  logic                     mem_re;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [7:0]               mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, mem_rdata,
    output if_ready, if_valid, if_rdata,
    output ls_ready, ls_valid, ls_rdata,
    output mem_re, mem_addr
  );

  // Requester/memory side
  modport master (
    output if_req, if_addr, ls_req, ls_addr, mem_rdata,
    input  if_ready, if_valid, if_rdata,
    input  ls_ready, ls_valid, ls_rdata,
    input  mem_re, mem_addr
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous-read memory between
// instruction fetch and load unit; each request becomes four byte reads.
module fetch_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, LAST, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  state_e                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  owner_e                   owner_q, owner_d;
  owner_e                   last_grant_q, last_grant_d;
  logic [2:0][7:0]          lane_q, lane_d;
  logic                     mem_re_q, mem_re_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                     if_valid_q, if_valid_d;
  logic                     ls_valid_q, ls_valid_d;
  logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]    ls_rdata_q, ls_rdata_d;

  logic                     grant_if, grant_ls;
  logic [ADDRESS_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0]    word;

  // Upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDRESS_WIDTH], bus.ls_addr[31:ADDRESS_WIDTH]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_LS;
      lane_q       <= '0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      if_valid_q   <= 1'b0;
      ls_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lane_q       <= lane_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      if_valid_q   <= if_valid_d;
      ls_valid_q   <= ls_valid_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_if || grant_ls) state_d = ISSUE;
      ISSUE:   if (cnt_q == 2'd3) state_d = LAST;
      LAST:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant: on a tie, the requester not served last wins.
  always_comb begin
    grant_if   = (state_q == IDLE) && bus.if_req &&
                 (!bus.ls_req || (last_grant_q == OWN_LS));
    grant_ls   = (state_q == IDLE) && bus.ls_req && !grant_if;
    grant_addr = grant_if ? bus.if_addr[ADDRESS_WIDTH-1:0]
                          : bus.ls_addr[ADDRESS_WIDTH-1:0];
    word       = {bus.mem_rdata, lane_q};
  end

  // Datapath; memory strobes are registered one cycle ahead so mem_re and
  // mem_addr come straight from flops.
  always_comb begin
    cnt_d        = cnt_q;
    base_d       = base_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lane_d       = lane_q;
    mem_re_d     = mem_re_q;
    mem_addr_d   = mem_addr_q;
    if_valid_d   = 1'b0;
    ls_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_if || grant_ls) begin
          base_d       = grant_addr;
          owner_d      = grant_if ? OWN_IF : OWN_LS;
          last_grant_d = grant_if ? OWN_IF : OWN_LS;
          cnt_d        = '0;
          mem_re_d     = 1'b1;
          mem_addr_d   = grant_addr;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q != 2'd0) lane_d[cnt_q - 2'd1] = bus.mem_rdata;
        if (cnt_q != 2'd3) begin
          mem_re_d   = 1'b1;
          mem_addr_d = base_q + ADDRESS_WIDTH'(cnt_q) + ADDRESS_WIDTH'(1);
        end else begin
          mem_re_d   = 1'b0;
        end
      end
      LAST: begin
        if (owner_q == OWN_IF) begin
          if_rdata_d = word;
          if_valid_d = 1'b1;
        end else begin
          ls_rdata_d = word;
          ls_valid_d = 1'b1;
        end
      end
      RESP: ;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.if_ready = grant_if;
    bus.ls_ready = grant_ls;
    bus.if_valid = if_valid_q;
    bus.ls_valid = ls_valid_q;
    bus.if_rdata = if_rdata_q;
    bus.ls_rdata = ls_rdata_q;
    bus.mem_re   = mem_re_q;
    bus.mem_addr = mem_addr_q;
  end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Sequences and shares one byte-wide, synchronous-read program/data memory between two word-read requesters: instruction fetch (IF) and load unit (LS).
- Each accepted request becomes four byte reads at addr+0..addr+3.
- The four bytes are assembled little-endian into a 32-bit word and returned with a one-cycle valid pulse.
- Sits between the fetch/load stages and the byte memory array; the memory array itself is loaded by $readmemh and is outside this block.

Parameters:
- ADDRESS_WIDTH, 16, width of the byte address driven to memory (memory depth 2**ADDRESS_WIDTH bytes).
- DATA_WIDTH, 32, returned word width; only 32 is supported (4 bytes).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  IF read request; held with if_addr until accepted.
- if_addr  in  32  IF byte address; only bits [ADDRESS_WIDTH-1:0] used.
- if_ready  out  1  combinational; high in the cycle the IF request is accepted.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_WIDTH  IF word {b3,b2,b1,b0}.
- ls_req  in  1  LS read request; held with ls_addr until accepted.
- ls_addr  in  32  LS byte address.
- ls_ready  out  1  LS accept, same rules as if_ready.
- ls_valid  out  1  LS one-cycle pulse.
- ls_rdata  out  DATA_WIDTH  LS word.
- mem_re  out  1  byte read enable to memory.
- mem_addr  out  ADDRESS_WIDTH  byte address to memory.
- mem_rdata  in  8  byte from memory, valid the cycle after mem_re.

Behaviour:
- Reset (rst_n=0 at a clock edge), applied regardless of current state, aborting any transfer in progress:
  - state=IDLE; if_valid=ls_valid=0; if_rdata=ls_rdata=0; mem_re=0; mem_addr=0; byte counter=0; last_grant=LS.
  - No valid pulse is emitted for an aborted transfer.
- States: IDLE, ISSUE (cnt 0..3), LAST, RESP.
- Acceptance (IDLE only). if_ready/ls_ready are 0 in every other state.
  - Only one requesting: that one is granted.
  - Both requesting: the requester not in last_grant is granted (round-robin). After reset, IF wins the first tie.
  - The granted ready is high combinationally in the accept cycle A.
  - On A, register base=addr[ADDRESS_WIDTH-1:0], owner, last_grant=owner, cnt=0; go to ISSUE.
- ISSUE (cycles A+1..A+4):
  - mem_re=1, mem_addr=base+cnt, computed modulo 2**ADDRESS_WIDTH (wraps, no error).
  - When cnt>=1, capture mem_rdata into byte lane cnt-1.
  - cnt increments; after cnt=3 go to LAST.
- LAST (A+5): mem_re=0; capture mem_rdata into lane 3; go to RESP.
- RESP (A+6):
  - Owner's valid=1 for exactly one cycle; owner's rdata updates to the assembled word on entry to RESP.
  - Next state IDLE (A+7).
- Latency: accept to valid is 6 cycles. Maximum throughput is one word per 7 cycles.
- rdata of each port holds its last delivered word until that port's next response. The non-owner's rdata and valid are untouched.
- Misaligned addresses are legal: any byte address is fetched byte-granular.
- A requester may drop req before acceptance; nothing is then issued for it.
- Requests arriving during a transfer are ignored until IDLE.
- Upper address bits [31:ADDRESS_WIDTH] are ignored.
- mem_addr holds its last value when mem_re=0.
- if_valid and ls_valid are never high in the same cycle.

Test Plan:
- Reset, then IF single read: memory bytes 0x00..0x03 = 13,00,00,00; if_req=1, if_addr=0.
  - Required: if_ready high at A; mem_re A+1..A+4 with addr 0,1,2,3; if_valid only at A+6; if_rdata=0x00000013.
- Simultaneous if_req and ls_req every cycle, if_addr=0x10, ls_addr=0x20:
  - Grants alternate IF, LS, IF, LS, with accepts 7 cycles apart.
  - ls_rdata = word at 0x20; if_rdata unchanged during LS responses.
- Wrap-around: ADDRESS_WIDTH=16, if_addr=0x0001FFFE.
  - mem_addr sequence FFFE, FFFF, 0000, 0001.
  - Word = {m[1],m[0],m[FFFF],m[FFFE]}.
- Misaligned LS read at 0x0003 with m[3..6]=AA,BB,CC,DD -> ls_rdata=0xDDCCBBAA.
- Reset mid-transfer: assert rst_n=0 at A+3 for one cycle.
  - No valid pulse; outputs zero; mem_re=0.
  - Next tie after release grants IF first.
- Request during busy: ls_req raised at A+2 while IF in progress.
  - ls_ready stays 0 until IDLE at A+7, then LS is accepted at A+7.
